mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Parametrised iterative multiply/divide unit that produces the HI/LO results for the multicycle CPU datapath. It generalises operand width and adds unsigned variants (MULTU/DIVU) alongside signed MULT/DIV. It also adds an explicit start/busy/done handshake and divide-by-zero signalling. The control FSM pulses start, waits for done, then loads HI/LO from this unit's outputs.

Parameters:
WIDTH, 32, operand width in bits; hi/lo are each WIDTH bits; legal range 4..64.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only while idle.
op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU; sampled with start.
a  input  WIDTH  multiplicand / dividend; sampled with start.
b  input  WIDTH  multiplier / divisor; sampled with start.
busy  output  1  operation in progress.
done  output  1  one-cycle completion pulse.
div_zero  output  1  one-cycle pulse, coincident with done, for a DIV/DIVU with b==0.
hi  output  WIDTH  product upper half / remainder.
lo  output  WIDTH  product lower half / quotient.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-low. While it is low: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
- Reset mid-operation: the operation is abandoned immediately; no done pulse follows.
- State sequence: IDLE -> RUN -> FIX -> FINISH -> IDLE. All outputs are registered.
- Edge 0 is the clock edge that samples start=1 in IDLE. At edge 0:
  - operands are latched;
  - signed ops convert operands to magnitudes and record the result signs;
  - busy rises; state goes to RUN with counter=WIDTH.
- RUN, one iteration per cycle for WIDTH cycles (edges 1..WIDTH), counter decrements:
  - MULT/MULTU: shift-add, one multiplier bit per cycle.
  - DIV/DIVU: restoring division, one quotient bit per cycle.
- FIX (edge WIDTH+1): two's-complement negation where required.
  - MULT: the 2*WIDTH product is negated when the operand signs differ.
  - DIV: the quotient is negated when the signs differ; the remainder takes the sign of the dividend.
- FINISH (edge WIDTH+2): hi/lo updated, done=1, busy=0. done is high for exactly one cycle; hi/lo then hold until the next accepted operation.
- Divide by zero (DIV/DIVU with b==0): detected at edge 0 and no iteration is run.
  - At edge 1: done=1 and div_zero=1; busy stays 0.
  - hi/lo are not modified.
- Overflow case: DIV with a = most-negative value and b = all ones gives lo = most-negative value, hi = 0 (wrap, defined).
- MULTU/DIVU treat operands as unsigned; no sign fix-up is applied.
- start while busy, or in the done cycle: ignored, no queueing. A new start is accepted from the first cycle after done.
- Operands a/b may change freely after edge 0.

Decomposition:
- Shared package mdu_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state enum IDLE/RUN/FIX/FINISH;
  - negate helper function.
- Sub-module mdu_iter_core: registered shift-add / restoring-divide step datapath (accumulator, shift register, counter). mult_div_unit owns the FSM, sign handling and output registers.

Test Plan:
All scenarios use WIDTH=32.
1. MULT, a=FFFFFFFE, b=00000003 -> hi=FFFFFFFF, lo=FFFFFFFA; done only at edge 34; busy high for edges 1..33.
2. MULTU with the same operands -> hi=00000002, lo=FFFFFFFA. Then DIVU a=7, b=2 -> lo=00000003, hi=00000001.
3. DIV a=FFFFFFF9, b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. Then DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
4. After test 2, DIV with b=0 -> done=1 and div_zero=1 at edge 1, busy never high, hi/lo remain 00000001/00000003.
5. start pulsed again at edge 5 of a MULT -> ignored; exactly one done at edge 34; a start at edge 35 is accepted.
6. reset driven low mid-RUN at cycle 10 -> busy, done, hi and lo go to 0 without waiting for a clock edge; no done after release; the next start completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, control state enum and a two's-complement negate helper.
package mdu_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   // Widest value the negate helper handles: a full 2*WIDTH product at WIDTH=64.
   localparam int MAX_W = 128;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      FINISH
   } state_t;

   // Callers zero-extend into MAX_W and size-cast the result back down.
   function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] v);
      return ~v + MAX_W'(1);
   endfunction

endpackage

// File: rtl/mult_div_unit_iter_core.sv
// Iteration datapath: one shift-add multiply step or one restoring divide
// step per cycle, with a down-counter flagging the final iteration.
// Multiply: acc:sreg holds the running product, sreg starts as the multiplier.
// Divide:   acc is the partial remainder, sreg shifts dividend out and quotient in.
module mdu_iter_core
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] sreg,
   output logic             last_iter
);

   logic [WIDTH-1:0] opd;
   logic             mode_div;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] rem_diff;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] sreg_nxt;

   // Next accumulator / shift register for whichever step the mode selects.
   always_comb begin
      add_sum   = {1'b0, acc} + {1'b0, opd & {WIDTH{sreg[0]}}};
      rem_shift = {acc, sreg[WIDTH-1]};
      // Only used when rem_shift >= opd, so the true difference fits in WIDTH bits.
      rem_diff  = rem_shift[WIDTH-1:0] - opd;
      acc_nxt   = acc;
      sreg_nxt  = sreg;
      if (mode_div) begin
         if (rem_shift >= {1'b0, opd}) begin
            acc_nxt  = rem_diff;
            sreg_nxt = {sreg[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt  = rem_shift[WIDTH-1:0];
            sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nxt  = add_sum[WIDTH:1];
         sreg_nxt = {add_sum[0], sreg[WIDTH-1:1]};
      end
   end

   // Terminal count: the step taken while cnt==1 is the last one.
   assign last_iter = (cnt == CNT_W'(1));

   // Load operands on acceptance, then advance one iteration per step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc      <= '0;
         sreg     <= '0;
         opd      <= '0;
         mode_div <= 1'b0;
         cnt      <= '0;
      end else if (load) begin
         acc      <= '0;
         sreg     <= is_div ? opa : opb;
         opd      <= is_div ? opb : opa;
         mode_div <= is_div;
         cnt      <= CNT_W'(WIDTH);
      end else if (step) begin
         acc  <= acc_nxt;
         sreg <= sreg_nxt;
         cnt  <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and divide producing HI/LO, with a
// start/busy/done handshake and divide-by-zero flag.
//
//   state  | meaning
//   IDLE   | waiting for start; operands, magnitudes and result signs latched on accept
//   RUN    | WIDTH iterations in the core, one per cycle
//   FIX    | apply sign correction into the result holding registers
//   FINISH | publish hi/lo (skipped on divide-by-zero), pulse done
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int PW    = 2 * WIDTH;

   state_t           state;
   logic             is_div;
   logic             neg_q;
   logic             neg_r;
   logic             dz;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;

   logic             op_div;
   logic             signed_op;
   logic             sign_a;
   logic             sign_b;
   logic             dz_req;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   logic             core_load;
   logic             core_step;
   logic             core_last;
   logic [WIDTH-1:0] core_acc;
   logic [WIDTH-1:0] core_sreg;

   logic [PW-1:0]    prod;
   logic [PW-1:0]    prod_neg;
   logic [WIDTH-1:0] quo_neg;
   logic [WIDTH-1:0] rem_neg;

   // Operand decode: unsigned ops never see a sign, so no fix-up follows.
   always_comb begin
      op_div    = op[1];
      signed_op = (op == OP_MULT) || (op == OP_DIV);
      sign_a    = signed_op & a[WIDTH-1];
      sign_b    = signed_op & b[WIDTH-1];
      dz_req    = op_div && (b == '0);
      mag_a     = sign_a ? WIDTH'(negate(MAX_W'(a))) : a;
      mag_b     = sign_b ? WIDTH'(negate(MAX_W'(b))) : b;
   end

   // Negated forms of the raw core result for the FIX step.
   always_comb begin
      prod     = {core_acc, core_sreg};
      prod_neg = PW'(negate(MAX_W'(prod)));
      quo_neg  = WIDTH'(negate(MAX_W'(core_sreg)));
      rem_neg  = WIDTH'(negate(MAX_W'(core_acc)));
   end

   assign core_load = (state == IDLE) && start && !dz_req;
   assign core_step = (state == RUN);

   mdu_iter_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .load      (core_load),
      .step      (core_step),
      .is_div    (op_div),
      .opa       (mag_a),
      .opb       (mag_b),
      .acc       (core_acc),
      .sreg      (core_sreg),
      .last_iter (core_last)
   );

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dz       <= 1'b0;
         res_hi   <= '0;
         res_lo   <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div <= op_div;
                  neg_q  <= sign_a ^ sign_b;
                  neg_r  <= sign_a;
                  if (dz_req) begin
                     // No iterations; busy never rises for a divide by zero.
                     dz    <= 1'b1;
                     state <= FINISH;
                  end else begin
                     dz    <= 1'b0;
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (core_last) state <= FIX;
            end
            FIX: begin
               if (is_div) begin
                  // Quotient sign from operand signs; remainder follows the dividend.
                  res_lo <= neg_q ? quo_neg : core_sreg;
                  res_hi <= neg_r ? rem_neg : core_acc;
               end else begin
                  {res_hi, res_lo} <= neg_q ? prod_neg : prod;
               end
               state <= FINISH;
            end
            FINISH: begin
               done     <= 1'b1;
               busy     <= 1'b0;
               div_zero <= dz;
               if (!dz) begin
                  hi <= res_hi;
                  lo <= res_lo;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32: vector table plus
// hand-written handshake, start-while-busy and mid-run reset sequences.
module tb_mult_div_unit;

   localparam logic [1:0] MULT  = 2'b00;
   localparam logic [1:0] MULTU = 2'b01;
   localparam logic [1:0] DIV   = 2'b10;
   localparam logic [1:0] DIVU  = 2'b11;
   localparam int NV = 15;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks;
   int failures;

   vec_t vecs [NV];

   mult_div_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Issue one operation sampled at edge 0; report first done edge (relative),
   // results at that edge, busy-profile violations and done one edge later.
   task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic expect_dz,
                         output logic [31:0] g_hi, output logic [31:0] g_lo, output logic g_dz,
                         output int g_edge, output int g_busy_bad, output logic g_after);
      g_hi = 'x;
      g_lo = 'x;
      g_dz = 1'bx;
      g_edge = -1;
      g_after = 1'bx;
      @(negedge clk);
      op = o; a = va; b = vb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      op = 2'($urandom_range(0, 3));
      g_busy_bad = (busy !== !expect_dz) ? 1 : 0;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            g_edge = e;
            g_hi = hi;
            g_lo = lo;
            g_dz = div_zero;
            if (busy !== 1'b0) g_busy_bad++;
            break;
         end
         if (busy !== !expect_dz) g_busy_bad++;
      end
      if (g_edge > 0) begin
         @(posedge clk); #1;
         g_after = done;
      end
   endtask

   initial begin
      logic [31:0] g_hi;
      logic [31:0] g_lo;
      logic        g_dz;
      logic        g_after;
      int          g_edge;
      int          g_busy_bad;
      int          done_cnt;
      int          first;
      logic [31:0] c_hi;
      logic [31:0] c_lo;

      checks = 0;
      failures = 0;

      vecs[0]  = '{MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 34};
      vecs[1]  = '{MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1'b0, 34};
      vecs[2]  = '{DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 34};
      vecs[3]  = '{DIV,   32'h00000005, 32'h00000000, 32'h00000001, 32'h00000003, 1'b1, 1};
      vecs[4]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
      vecs[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
      vecs[6]  = '{MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
      vecs[7]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
      vecs[8]  = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 34};
      vecs[9]  = '{DIVU,  32'h00000003, 32'h00000007, 32'h00000003, 32'h00000000, 1'b0, 34};
      vecs[10] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
      vecs[11] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
      vecs[12] = '{DIVU,  32'h12345678, 32'h00000000, 32'h40000000, 32'h00000000, 1'b1, 1};
      vecs[13] = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 34};
      vecs[14] = '{MULTU, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 1'b0, 34};

      reset = 1'b0;
      start = 1'b0;
      op = MULT;
      a = '0;
      b = '0;
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dz", 64'(div_zero), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dz,
                g_hi, g_lo, g_dz, g_edge, g_busy_bad, g_after);
         check($sformatf("v%0d_done_edge", i), 64'(g_edge), 64'(vecs[i].lat));
         check($sformatf("v%0d_hi", i), 64'(g_hi), 64'(vecs[i].hi));
         check($sformatf("v%0d_lo", i), 64'(g_lo), 64'(vecs[i].lo));
         check($sformatf("v%0d_div_zero", i), 64'(g_dz), 64'(vecs[i].dz));
         check($sformatf("v%0d_busy_profile", i), 64'(g_busy_bad), 64'd0);
         check($sformatf("v%0d_done_one_cycle", i), 64'(g_after), 64'd0);
      end

      // start pulsed again at edge 5 is ignored; start at edge 35 is accepted
      @(negedge clk);
      op = MULT; a = 32'd5; b = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      done_cnt = 0;
      first = -1;
      c_hi = 'x;
      c_lo = 'x;
      for (int e = 1; e <= 34; e++) begin
         if (e == 5) begin
            op = MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
         end
         @(posedge clk); #1;
         if (e == 5) start = 1'b0;
         if (done === 1'b1) begin
            done_cnt++;
            if (first < 0) begin
               first = e;
               c_hi = hi;
               c_lo = lo;
            end
         end
      end
      check("busy_start_done_count", 64'(done_cnt), 64'd1);
      check("busy_start_done_edge", 64'(first), 64'd34);
      check("busy_start_hi", 64'(c_hi), 64'h0);
      check("busy_start_lo", 64'(c_lo), 64'h1E);
      // still in the done cycle: drive the next start for edge 35
      op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("edge35_accept_busy", 64'(busy), 64'd1);
      first = -1;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            first = e;
            c_hi = hi;
            c_lo = lo;
            break;
         end
      end
      check("edge35_done_edge", 64'(first), 64'd34);
      check("edge35_hi", 64'(c_hi), 64'h2);
      check("edge35_lo", 64'(c_lo), 64'hE);

      // asynchronous reset in the middle of RUN
      @(negedge clk);
      op = MULT; a = 32'h1111; b = 32'h3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("pre_rst_busy", 64'(busy), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_done", 64'(done), 64'd0);
      check("async_rst_hi", 64'(hi), 64'd0);
      check("async_rst_lo", 64'(lo), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      done_cnt = 0;
      for (int e = 0; e < 40; e++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) done_cnt++;
      end
      check("post_rst_no_done", 64'(done_cnt), 64'd0);
      run_op(MULTU, 32'h00001234, 32'h00000010, 1'b0,
             g_hi, g_lo, g_dz, g_edge, g_busy_bad, g_after);
      check("post_rst_done_edge", 64'(g_edge), 64'd34);
      check("post_rst_hi", 64'(g_hi), 64'h0);
      check("post_rst_lo", 64'(g_lo), 64'h00012340);
      check("post_rst_busy_profile", 64'(g_busy_bad), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
